// File: rtl/gullfaxi_router_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : gullfaxi_router_if                                         |
// | Description : Bus bundle for gullfaxi_router: one input word stream      |
// |               (valid/ready/end) and NPORTS output ports with req/grant,  |
// |               plus the discarded-packet counter.                         |
// |               slave  : the router side (drives I0_ready and all O_*).    |
// |               master : the environment (drives input words and grants).  |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
interface gullfaxi_router_if #(
  parameter int DW     = 8,
  parameter int NPORTS = 4
);
  localparam int LW = DW - $clog2(NPORTS);

  logic                 I0_valid;
  logic [DW-1:0]        I0_data;
  logic                 I0_end;
  logic                 I0_ready;
  logic [NPORTS-1:0]    O_start;
  logic [NPORTS*LW-1:0] O_length;
  logic [NPORTS*DW-1:0] O_data;
  logic [NPORTS-1:0]    O_end;
  logic [NPORTS-1:0]    O_req;
  logic [NPORTS-1:0]    O_grant;
  logic [15:0]          drop_cnt;

  modport slave (
    input  I0_valid, I0_data, I0_end, O_grant,
    output I0_ready, O_start, O_length, O_data, O_end, O_req, drop_cnt
  );

  modport master (
    output I0_valid, I0_data, I0_end, O_grant,
    input  I0_ready, O_start, O_length, O_data, O_end, O_req, drop_cnt
  );
endinterface
`default_nettype wire

// File: rtl/gullfaxi_router.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : gullfaxi_router                                            |
// | Description : Single-input packet router. Words are buffered in a        |
// |               circular FIFO; a read FSM decodes each header              |
// |               {length, port}, requests the target port and streams the   |
// |               payload once granted. Malformed packets are discarded and  |
// |               counted (saturating at 16'hFFFF).                          |
// | Ports       : clk, reset (synchronous, active-high)                      |
// |               bus.slave : I0_valid/I0_data/I0_end/I0_ready input stream, |
// |               O_start/O_length/O_data/O_end/O_req/O_grant per port,      |
// |               drop_cnt.                                                  |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module gullfaxi_router #(
  parameter int DW        = 8,
  parameter int NPORTS    = 4,
  parameter int DEPTH     = 64,
  parameter int MAXLENGTH = 12
) (
  input logic              clk,
  input logic              reset,
  gullfaxi_router_if.slave bus
);
  localparam int c_PW  = $clog2(NPORTS);
  localparam int c_LW  = DW - c_PW;
  localparam int c_AW  = $clog2(DEPTH);
  localparam int c_AW1 = c_AW + 1;
  localparam int c_PW1 = c_PW + 1;

  localparam logic [c_AW:0]   c_DEPTH     = c_AW1'(DEPTH);
  localparam logic [c_AW:0]   c_READY_MIN = c_AW1'(MAXLENGTH + 1);
  localparam logic [c_AW:0]   c_CNT_ONE   = c_AW1'(1);
  localparam logic [c_AW-1:0] c_PTR_ONE   = c_AW'(1);
  localparam logic [c_LW-1:0] c_MAXLEN    = c_LW'(MAXLENGTH);
  localparam logic [c_LW-1:0] c_LEN_ONE   = c_LW'(1);
  localparam logic [c_PW:0]   c_NPORTS    = c_PW1'(NPORTS);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HDR  = 3'd1,
    S_REQ  = 3'd2,
    S_SEND = 3'd3,
    S_DROP = 3'd4
  } state_t;

  state_t r_state, w_state_next;

  // FIFO storage holds {end, data}; reset only clears pointers and counts.
  logic [DW:0]       r_mem [DEPTH];
  logic [c_AW-1:0]   r_wr_ptr, r_rd_ptr;
  logic [c_AW:0]     r_n_elems, r_n_pkts;
  logic [DW:0]       r_rd_word;

  logic [c_LW-1:0]   r_len, r_cnt, r_pay_idx;
  logic [c_PW-1:0]   r_port;
  logic              r_pay_vld;
  logic [15:0]       r_drop_cnt;

  logic [NPORTS-1:0]      r_o_req, r_o_start, r_o_end;
  logic [NPORTS*c_LW-1:0] r_o_len;
  logic [NPORTS*DW-1:0]   r_o_data;

  logic [NPORTS-1:0]      w_o_req, w_o_start, w_o_end;
  logic [NPORTS*c_LW-1:0] w_o_len;
  logic [NPORTS*DW-1:0]   w_o_data;

  logic            w_ready, w_push, w_pop, w_pop_pay, w_hdr_pop;
  logic            w_drop_inc, w_hdr_load, w_grant_hit, w_hdr_bad, w_port_bad;
  logic [c_LW-1:0] w_hdr_len;
  logic [c_PW-1:0] w_hdr_port;

  // Ready only while a maximum-length packet plus header still fits.
  assign w_ready   = (c_DEPTH - r_n_elems) >= c_READY_MIN;
  assign w_push    = bus.I0_valid && w_ready;
  assign w_hdr_pop = (r_state == S_IDLE) && w_pop;

  assign w_hdr_len  = r_rd_word[DW-1:c_PW];
  assign w_hdr_port = r_rd_word[c_PW-1:0];

  generate
    if ((1 << c_PW) == NPORTS) begin : g_port_pow2
      assign w_port_bad = 1'b0;
    end else begin : g_port_range
      assign w_port_bad = ({1'b0, w_hdr_port} >= c_NPORTS);
    end
  endgenerate

  assign w_hdr_bad = w_port_bad || (w_hdr_len == '0) || (w_hdr_len > c_MAXLEN);

  // A grant only counts once our request is actually visible on the port.
  assign w_grant_hit = (r_state == S_REQ) && r_o_req[r_port] && bus.O_grant[r_port];

  always_comb begin
    w_state_next = r_state;
    w_pop        = 1'b0;
    w_pop_pay    = 1'b0;
    w_drop_inc   = 1'b0;
    w_hdr_load   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_n_pkts != '0) begin
          w_pop        = 1'b1;
          w_state_next = S_HDR;
        end
      end
      S_HDR: begin
        if (w_hdr_bad) begin
          w_drop_inc   = 1'b1;
          w_state_next = r_rd_word[DW] ? S_IDLE : S_DROP;
        end else begin
          w_hdr_load   = 1'b1;
          w_state_next = S_REQ;
        end
      end
      S_REQ: begin
        if (w_grant_hit) begin
          w_pop        = 1'b1;
          w_pop_pay    = 1'b1;
          w_state_next = S_SEND;
        end
      end
      S_SEND: begin
        // Stay one extra cycle after the last pop so the final word is
        // presented while the port is still owned.
        if (r_cnt < r_len) begin
          w_pop     = 1'b1;
          w_pop_pay = 1'b1;
        end else begin
          w_state_next = S_IDLE;
        end
      end
      S_DROP: begin
        // r_rd_word is the most recently popped word (header on entry).
        if (r_rd_word[DW]) begin
          w_state_next = S_IDLE;
        end else begin
          w_pop = 1'b1;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_o_req   = '0;
    w_o_start = '0;
    w_o_end   = '0;
    w_o_len   = '0;
    w_o_data  = '0;
    if ((r_state == S_REQ) || (r_state == S_SEND)) begin
      w_o_req[r_port]                  = (r_state == S_REQ) && !w_grant_hit;
      w_o_len[r_port*c_LW +: c_LW]     = r_len;
      if (r_pay_vld) begin
        w_o_data[r_port*DW +: DW] = r_rd_word[DW-1:0];
        w_o_start[r_port]         = (r_pay_idx == '0);
        w_o_end[r_port]           = (r_pay_idx == (r_len - c_LEN_ONE));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {bus.I0_end, bus.I0_data};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_n_elems  <= '0;
      r_n_pkts   <= '0;
      r_rd_word  <= '0;
      r_len      <= '0;
      r_cnt      <= '0;
      r_pay_idx  <= '0;
      r_port     <= '0;
      r_pay_vld  <= 1'b0;
      r_drop_cnt <= '0;
      r_o_req    <= '0;
      r_o_start  <= '0;
      r_o_end    <= '0;
      r_o_len    <= '0;
      r_o_data   <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr  <= r_rd_ptr + c_PTR_ONE;
        r_rd_word <= r_mem[r_rd_ptr];
      end
      case ({w_push, w_pop})
        2'b10:   r_n_elems <= r_n_elems + c_CNT_ONE;
        2'b01:   r_n_elems <= r_n_elems - c_CNT_ONE;
        default: r_n_elems <= r_n_elems;
      endcase
      case ({w_push && bus.I0_end, w_hdr_pop})
        2'b10:   r_n_pkts <= r_n_pkts + c_CNT_ONE;
        2'b01:   r_n_pkts <= r_n_pkts - c_CNT_ONE;
        default: r_n_pkts <= r_n_pkts;
      endcase
      if (w_hdr_load) begin
        r_len  <= w_hdr_len;
        r_port <= w_hdr_port;
        r_cnt  <= '0;
      end else if (w_pop_pay) begin
        r_cnt <= r_cnt + c_LEN_ONE;
      end
      r_pay_vld <= w_pop_pay;
      r_pay_idx <= r_cnt;
      if (w_drop_inc && (r_drop_cnt != 16'hFFFF)) begin
        r_drop_cnt <= r_drop_cnt + 16'd1;
      end
      r_o_req   <= w_o_req;
      r_o_start <= w_o_start;
      r_o_end   <= w_o_end;
      r_o_len   <= w_o_len;
      r_o_data  <= w_o_data;
    end
  end

  assign bus.I0_ready = w_ready;
  assign bus.O_req    = r_o_req;
  assign bus.O_start  = r_o_start;
  assign bus.O_end    = r_o_end;
  assign bus.O_length = r_o_len;
  assign bus.O_data   = r_o_data;
  assign bus.drop_cnt = r_drop_cnt;

endmodule
`default_nettype wire
